lifo_stack_ctrl: RTL



---
 rtl/lifo_stack_ctrl_if.sv | 37 +++
 rtl/lifo_stack_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/lifo_stack_ctrl_if.sv
// Command/status bundle between the debounced button front end and the LIFO engine.
// The o_errcnt field exists only when LIFO_ERRCNT_EN is defined.
interface lifo_stack_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          i_push;
    logic          i_pop;
    logic [DW-1:0] i_data;
    logic [DW-1:0] o_top;
    logic [AW:0]   o_count;
    logic          o_full;
    logic          o_empty;
    logic          o_busy;
    logic          o_ovf;
    logic          o_udf;
    logic          o_drop;
`ifdef LIFO_ERRCNT_EN
    logic [7:0]    o_errcnt;
`endif

    modport master (
        output i_push, i_pop, i_data,
        input  o_top, o_count, o_full, o_empty, o_busy, o_ovf, o_udf, o_drop
`ifdef LIFO_ERRCNT_EN
        , input o_errcnt
`endif
    );

    modport slave (
        input  i_push, i_pop, i_data,
        output o_top, o_count, o_full, o_empty, o_busy, o_ovf, o_udf, o_drop
`ifdef LIFO_ERRCNT_EN
        , output o_errcnt
`endif
    );
endinterface

// File: rtl/lifo_stack_ctrl.sv
// DEPTH-entry LIFO over a synchronous-read RAM, fed by debounced push/pop pulses.
// Define LIFO_ERRCNT_EN to add a saturating error-pulse counter (o_errcnt).
module lifo_stack_ctrl #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input logic              i_clk,
    input logic              i_rst_n,
    lifo_stack_ctrl_if.slave bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {S_IDLE, S_RDA, S_RDD} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] top_q, top_d;
    logic          full_q, empty_q;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          drop_q, drop_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW:0]   below_top;
    logic          wr_en;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data;

    // Entry under the current top, i.e. the new top after a pop.
    assign below_top = count_q - (AW+1)'(2);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        top_d     = top_q;
        rd_addr_d = rd_addr_q;
        wr_en     = 1'b0;
        ovf_d     = 1'b0;
        udf_d     = 1'b0;
        drop_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_push && bus.i_pop) begin
                    drop_d = 1'b1;
                end else if (bus.i_push) begin
                    if (full_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        top_d   = bus.i_data;
                        count_d = count_q + (AW+1)'(1);
                    end
                end else if (bus.i_pop) begin
                    if (empty_q) begin
                        udf_d = 1'b1;
                    end else if (count_q == (AW+1)'(1)) begin
                        // Last entry: nothing beneath it to fetch.
                        count_d = '0;
                        top_d   = '0;
                    end else begin
                        count_d   = count_q - (AW+1)'(1);
                        rd_addr_d = below_top[AW-1:0];
                        state_d   = S_RDA;
                    end
                end
            end
            S_RDA: begin
                drop_d  = bus.i_push | bus.i_pop;
                state_d = S_RDD;
            end
            S_RDD: begin
                drop_d  = bus.i_push | bus.i_pop;
                top_d   = rd_data;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            top_q     <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rd_addr_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            top_q     <= top_d;
            full_q    <= (count_d == (AW+1)'(DEPTH));
            empty_q   <= (count_d == '0);
            rd_addr_q <= rd_addr_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            drop_q    <= drop_d;
        end
    end

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[count_q[AW-1:0]] <= bus.i_data;
        rd_data <= mem[rd_addr_q];
    end

    assign bus.o_top   = top_q;
    assign bus.o_count = count_q;
    assign bus.o_full  = full_q;
    assign bus.o_empty = empty_q;
    assign bus.o_busy  = (state_q != S_IDLE);
    assign bus.o_ovf   = ovf_q;
    assign bus.o_udf   = udf_q;
    assign bus.o_drop  = drop_q;

`ifdef LIFO_ERRCNT_EN
    logic [7:0] errcnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            errcnt_q <= '0;
        end else if ((ovf_q || udf_q || drop_q) && errcnt_q != 8'hFF) begin
            errcnt_q <= errcnt_q + 8'd1;
        end
    end

    assign bus.o_errcnt = errcnt_q;
`endif
endmodule
